// File: rtl/alu32_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu32_seq_ctrl
// Function : Valid/ready sequencer for a 32-bit ALU; multiply by shift-add.
// Revision : 1.0
// ============================================================================

module alu32_seq_ctrl #(
  parameter logic [2:0] MUL_OP     = 3'b010,
  parameter bit         EARLY_EXIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        busy,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_result
);

  localparam logic [2:0] c_op_add   = 3'b000;
  localparam logic [4:0] c_last_cnt = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  cnt_q, cnt_d;

  logic        w_accept;
  logic        w_in_is_mul;
  logic [31:0] w_acc_step;
  logic        w_mul_last;

  assign in_ready    = (state_q == S_IDLE) && !flush;
  assign w_accept    = in_valid && in_ready;
  assign w_in_is_mul = (in_op == MUL_OP);
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign out_result  = result_q;

  // ALU adds mcand onto acc; keep the sum only when the current multiplier bit is set.
  assign w_acc_step  = mplier_q[0] ? alu_result : acc_q;
  assign w_mul_last  = (cnt_q == c_last_cnt) ||
                       (EARLY_EXIT && ((mplier_q >> 1) == 32'd0));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    alu_a    = 32'd0;
    alu_b    = 32'd0;
    alu_op   = c_op_add;

    case (state_q)
      S_IDLE: begin
        alu_a  = in_a;
        alu_b  = in_b;
        alu_op = w_in_is_mul ? c_op_add : in_op;
        if (w_accept) begin
          if (!w_in_is_mul) begin
            result_d = alu_result;
            state_d  = S_DONE;
          end else if (EARLY_EXIT && (in_b == 32'd0)) begin
            result_d = 32'd0;
            state_d  = S_DONE;
          end else begin
            acc_d    = 32'd0;
            mcand_d  = in_a;
            mplier_d = in_b;
            cnt_d    = 5'd0;
            state_d  = S_MUL;
          end
        end
      end

      S_MUL: begin
        alu_a    = acc_q;
        alu_b    = mcand_q;
        acc_d    = w_acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (w_mul_last) begin
          result_d = w_acc_step;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything, including a multiply finishing this cycle.
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= 32'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      result_q <= 32'd0;
      cnt_q    <= 5'd0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu32_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu32_seq_ctrl
// Function : Directed bench; fixed-iteration and early-exit instances side by side.
// Revision : 1.0
// ============================================================================

module tb_alu32_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b;

  logic        in_ready0, out_valid0, busy0;
  logic [31:0] out_result0, alu_a0, alu_b0, alu_result0;
  logic [2:0]  alu_op0;
  logic        in_ready1, out_valid1, busy1;
  logic [31:0] out_result1, alu_a1, alu_b1, alu_result1;
  logic [2:0]  alu_op1;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b011:  return a ^ b;
      3'b100:  return a & b;
      3'b101:  return a | b;
      3'b110:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b111:  return ~(a | b);
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  assign alu_result0 = alu_model(alu_a0, alu_b0, alu_op0);
  assign alu_result1 = alu_model(alu_a1, alu_b1, alu_op1);

  alu32_seq_ctrl #(.MUL_OP(3'b010), .EARLY_EXIT(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid0), .out_ready(out_ready), .out_result(out_result0), .busy(busy0),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_op(alu_op0), .alu_result(alu_result0)
  );

  alu32_seq_ctrl #(.MUL_OP(3'b010), .EARLY_EXIT(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid1), .out_ready(out_ready), .out_result(out_result1), .busy(busy1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_result(alu_result1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pop(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle0"}, 32'(busy0), 32'd0);
    check({tag, "_idle1"}, 32'(busy1), 32'd0);
  endtask

  task automatic single(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    #1;
    check({tag, "_alu_a"}, alu_a0, a);
    check({tag, "_alu_op"}, 32'(alu_op0), 32'(op));
    tick();
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_op = ~op;
    #1;
    check({tag, "_valid"}, 32'(out_valid0), 32'd1);
    check({tag, "_res0"}, out_result0, exp);
    check({tag, "_res1"}, out_result1, exp);
    check({tag, "_in_ready"}, 32'(in_ready0), 32'd0);
    pop(tag);
  endtask

  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat0_exp, input int lat1_exp);
    int lat0 = 0;
    int lat1 = 0;
    bit saw_mul_op = 1'b0;
    in_op = 3'b010; in_a = a; in_b = b; in_valid = 1'b1;
    #1;
    check({tag, "_idle_alu_op"}, 32'(alu_op0), 32'd0);
    tick();
    in_valid = 1'b0; in_a = 32'h5A5A5A5A; in_b = 32'hA5A5A5A5; in_op = 3'b111;
    #1;
    for (int lat = 1; lat <= 40; lat++) begin
      if (out_valid0 && lat0 == 0) lat0 = lat;
      if (out_valid1 && lat1 == 0) lat1 = lat;
      if (alu_op0 == 3'b010 || alu_op1 == 3'b010) saw_mul_op = 1'b1;
      if (lat0 != 0 && lat1 != 0) break;
      tick();
    end
    check({tag, "_lat0"}, 32'(lat0), 32'(lat0_exp));
    check({tag, "_lat1"}, 32'(lat1), 32'(lat1_exp));
    check({tag, "_res0"}, out_result0, exp);
    check({tag, "_res1"}, out_result1, exp);
    check({tag, "_no_op010"}, 32'(saw_mul_op), 32'd0);
  endtask

  initial begin
    int seen_valid;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 3'b000; in_a = 32'd0; in_b = 32'd0;
    #2;
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_valid", 32'(out_valid0), 32'd0);
    check("rst_result", out_result0, 32'd0);
    check("rst_in_ready", 32'(in_ready0), 32'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    single("add", 3'b000, 32'd5, 32'd7, 32'h0000000C);
    single("sub", 3'b001, 32'd3, 32'd5, 32'hFFFFFFFE);
    single("slt", 3'b110, 32'hFFFFFFFF, 32'd1, 32'h00000001);
    single("nor", 3'b111, 32'd0, 32'd0, 32'hFFFFFFFF);
    single("xor", 3'b011, 32'hF0F0A5A5, 32'h0FF0FFFF, 32'hFF005A5A);

    run_mul("mul_1234", 32'h00001234, 32'h00000010, 32'h00012340, 33, 6);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", out_result0, 32'h00012340);
      check("bp_valid", 32'(out_valid0), 32'd1);
      check("bp_in_ready", 32'(in_ready0), 32'd0);
      check("bp_busy", 32'(busy0), 32'd1);
    end
    pop("bp");

    run_mul("mul_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33, 33);
    pop("mul_ones");
    run_mul("mul_9x3", 32'd9, 32'd3, 32'h0000001B, 33, 3);
    pop("mul_9x3");
    run_mul("mul_9x0", 32'd9, 32'd0, 32'h00000000, 33, 1);
    pop("mul_9x0");

    in_op = 3'b000; in_a = 32'd4; in_b = 32'd4; in_valid = 1'b1; flush = 1'b1;
    #1;
    check("flush_blocks_ready", 32'(in_ready0), 32'd0);
    tick();
    in_valid = 1'b0; flush = 1'b0;
    #1;
    check("flush_no_accept", 32'(busy0), 32'd0);

    in_op = 3'b010; in_a = 32'h00001234; in_b = 32'h00000010; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush_idle0", 32'(busy0), 32'd0);
    check("flush_idle1", 32'(busy1), 32'd0);
    seen_valid = 0;
    repeat (40) begin
      if (out_valid0 || out_valid1) seen_valid = 1;
      tick();
    end
    check("flush_no_valid", 32'(seen_valid), 32'd0);
    single("add_after_flush", 3'b000, 32'd1, 32'd1, 32'h00000002);

    in_op = 3'b010; in_a = 32'h00001234; in_b = 32'h00000010; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy0", 32'(busy0), 32'd0);
    check("arst_busy1", 32'(busy1), 32'd0);
    check("arst_valid", 32'(out_valid0), 32'd0);
    check("arst_result0", out_result0, 32'd0);
    check("arst_result1", out_result1, 32'd0);
    #3 rst_n = 1'b1;
    seen_valid = 0;
    repeat (40) begin
      tick();
      if (out_valid0 || out_valid1) seen_valid = 1;
    end
    check("arst_no_valid", 32'(seen_valid), 32'd0);
    single("add_after_rst", 3'b000, 32'd5, 32'd7, 32'h0000000C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu32_seq_ctrl.md
Name: alu32_seq_ctrl

Overview:
Sequencing controller for the 32-bit 8-function ALU. Accepts one operation at a time over a valid/ready request channel and drives the ALU operand and opcode pins. Single-cycle functions complete in one pass. Multiply (opcode 010) has no combinational slot in the ALU, so the controller runs an iterative shift-add using the ALU add function. It returns results on a valid/ready response channel.

Parameters:
MUL_OP, 3'b010, opcode handled iteratively; never presented to the ALU.
EARLY_EXIT, 0, 1 = finish the multiply as soon as the remaining multiplier is zero; 0 = fixed 32 iterations.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort to IDLE
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid && in_ready
in_op  input  3  000 add, 001 sub, 010 mul, 011 xor, 100 and, 101 or, 110 slt, 111 nor
in_a  input  32  operand A
in_b  input  32  operand B
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid && out_ready
out_result  output  32  registered result
busy  output  1  high in any state except IDLE
alu_a  output  32  ALU operand A
alu_b  output  32  ALU operand B
alu_op  output  3  ALU function select
alu_result  input  32  combinational ALU result

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, out_valid=0, out_result=0, busy=0, and acc, mcand, mplier and iteration count all 0. Reset mid-operation drops the operation silently. No out_valid follows.
- States: IDLE, MUL, DONE. in_ready=1 only in IDLE and only when flush=0.
- IDLE: alu_a=in_a, alu_b=in_b. alu_op=in_op, except alu_op=000 when in_op==MUL_OP.
  - On accept with non-mul op: out_result<=alu_result, go to DONE. Latency: out_valid on the cycle after the accept edge.
  - On accept with MUL_OP: acc<=0, mcand<=in_a, mplier<=in_b, cnt<=0, go to MUL.
  - If EARLY_EXIT=1 and in_b==0: go straight to DONE with out_result=0.
- MUL, one iteration per cycle: alu_op=000, alu_a=acc, alu_b=mcand.
  - acc<=mplier[0] ? alu_result : acc.
  - mcand<=mcand<<1 and mplier<=mplier>>1, both logical shifts.
  - cnt<=cnt+1.
- MUL exit: leave when cnt==31, or (EARLY_EXIT=1 and (mplier>>1)==0). Latch out_result from the final acc update and go to DONE.
- MUL result: the low 32 bits of the unsigned product, which are also the correct low 32 bits for two's-complement operands. Overflow is discarded.
- MUL timing: with EARLY_EXIT=0, out_valid is first seen exactly 33 cycles after the accept edge.
- DONE: out_valid=1. out_result and out_valid hold stable until out_ready=1, then return to IDLE on that edge. in_ready=0 in DONE, so there is no same-cycle accept. Peak throughput is one single-cycle op per 2 clocks.
- Outside IDLE/MUL: alu_a=alu_b=0, alu_op=000.
- flush=1 in any state: next state IDLE, out_valid=0, and any in-progress result is discarded. flush beats a simultaneous accept; in_ready=0 while flush=1.
- in_a, in_b and in_op are sampled only on the accept edge; later changes have no effect.
- slt results come straight from the ALU (signed compare, 0 or 1 in bit 0).

Test Plan:
- add 5 + 7: accept at edge T → out_valid=1, out_result=0x0000000C at T+1. in_ready=0 until the handshake completes.
- sub 3 − 5 → 0xFFFFFFFE. slt a=0xFFFFFFFF, b=1 → 0x00000001. nor 0,0 → 0xFFFFFFFF. Each has 1-cycle latency.
- mul 0x00001234 × 0x00000010 with EARLY_EXIT=0 → 0x00012340, out_valid exactly 33 cycles after accept. mul 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001. During MUL, alu_op never equals 010.
- Backpressure: result ready with out_ready=0 for 5 cycles → out_result held constant, in_ready=0, busy=1. out_ready=1 → IDLE on the next edge.
- flush asserted at iteration 10 of a mul → IDLE next cycle, no out_valid. A new add 1+1 then returns 0x00000002 normally. Repeat with rst_n pulsed low mid-mul → all outputs reset asynchronously.
- EARLY_EXIT=1:
  - mul 9 × 3 → 0x0000001B, out_valid 3 cycles after accept.
  - mul 9 × 0 → 0, out_valid 1 cycle after accept.
